data_path: RTL and testbench

- 8-bit datapath: a 16-entry x 8-bit register file plus a combinational ALU.
- The controller drives a 12-bit operand field, an ALU command and a control-signal bundle.
- Each clock the datapath either writes an immediate into a register (init) or writes the ALU result of two registers into a destination register.
- Sits between the instruction decoder/controller and the rest of the CPU.

---
 rtl/data_path_pkg.sv | 45 ++++
 rtl/data_path_alu_unit.sv | 79 +++++++
 rtl/data_path.sv | 86 ++++++++
 tb/tb_data_path.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/data_path_pkg.sv
// ---------------------------------------------------------------------------
// data_path_pkg.sv
// Shared type and constant definitions for the data_path block.
//   package alu           : AluCmd, the 4-bit ALU operation select
//   package ctrl          : CtrlSig, the controller's write-control bundle
//   package data_path_pkg : default widths and operand-field slice positions
// Ports: none (packages only).
// ---------------------------------------------------------------------------
package alu;
   typedef enum logic [3:0] {
      ADD   = 4'd0,
      SUB   = 4'd1,
      AND   = 4'd2,
      OR    = 4'd3,
      XOR   = 4'd4,
      NOT   = 4'd5,
      SHL   = 4'd6,
      SHR   = 4'd7,
      PASSA = 4'd8,
      PASSB = 4'd9
   } AluCmd;
endpackage

package ctrl;
   typedef struct packed {
      logic reg_wr_en;   // 1 = write the destination register on this edge
      logic dst_in_sel;  // 1 = immediate, 0 = ALU result
   } CtrlSig;
endpackage

package data_path_pkg;
   localparam int DATA_W_DEF   = 8;
   localparam int NUM_REGS_DEF = 16;
   localparam int OPND_W       = 12;

   // Operand field layout: {dst[11:8], imm[7:0]} or {dst, srca[7:4], srcb[3:0]}
   localparam int DST_MSB  = 11;
   localparam int DST_LSB  = 8;
   localparam int SRCA_MSB = 7;
   localparam int SRCA_LSB = 4;
   localparam int SRCB_MSB = 3;
   localparam int SRCB_LSB = 0;
   localparam int IMM_MSB  = 7;
   localparam int IMM_LSB  = 0;
endpackage

// File: rtl/data_path_alu_unit.sv
// ---------------------------------------------------------------------------
// alu_unit
// Purely combinational ALU for the data_path block.
// Ports:
//   a, b     : operands (DATA_W bits, treated as unsigned for carry and as
//              two's complement for overflow)
//   cmd      : alu::AluCmd operation select
//   result   : DATA_W-bit result, wraps modulo 2**DATA_W
//   carry    : ADD carry out, SUB borrow, SHL/SHR shifted-out bit, else 0
//   overflow : signed overflow for ADD/SUB, else 0
// Undefined cmd encodings produce result = 0, carry = 0, overflow = 0.
// ---------------------------------------------------------------------------
module alu_unit
   import data_path_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  alu::AluCmd        cmd,
   output logic [DATA_W-1:0] result,
   output logic              carry,
   output logic              overflow
);

   logic [DATA_W:0] sum_u;
   logic [DATA_W:0] dif_u;

   // Overflow when both operands share a sign and the result does not.
   function automatic logic add_ovf(input logic signed [DATA_W-1:0] x,
                                    input logic signed [DATA_W-1:0] y,
                                    input logic signed [DATA_W-1:0] r);
      return ((x < 0) == (y < 0)) && ((r < 0) != (x < 0));
   endfunction

   // Overflow when operand signs differ and the result sign leaves x's sign.
   function automatic logic sub_ovf(input logic signed [DATA_W-1:0] x,
                                    input logic signed [DATA_W-1:0] y,
                                    input logic signed [DATA_W-1:0] r);
      return ((x < 0) != (y < 0)) && ((r < 0) != (x < 0));
   endfunction

   always_comb begin
      // One extra bit captures carry (ADD) or borrow (SUB, set when a < b).
      sum_u    = {1'b0, a} + {1'b0, b};
      dif_u    = {1'b0, a} - {1'b0, b};
      result   = '0;
      carry    = 1'b0;
      overflow = 1'b0;
      case (cmd)
         alu::ADD: begin
            result   = sum_u[DATA_W-1:0];
            carry    = sum_u[DATA_W];
            overflow = add_ovf(a, b, sum_u[DATA_W-1:0]);
         end
         alu::SUB: begin
            result   = dif_u[DATA_W-1:0];
            carry    = dif_u[DATA_W];
            overflow = sub_ovf(a, b, dif_u[DATA_W-1:0]);
         end
         alu::AND:   result = a & b;
         alu::OR:    result = a | b;
         alu::XOR:   result = a ^ b;
         alu::NOT:   result = ~a;
         alu::SHL: begin
            result = a << 1;
            carry  = a[DATA_W-1];
         end
         alu::SHR: begin
            result = a >> 1;
            carry  = a[0];
         end
         alu::PASSA: result = a;
         alu::PASSB: result = b;
         default: ;
      endcase
   end

endmodule

// File: rtl/data_path.sv
// ---------------------------------------------------------------------------
// data_path
// 16 x 8-bit register file with a combinational ALU. Each enabled clock edge
// writes either the operand immediate or the ALU result of two registers into
// the destination register.
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset, clears all registers (and flags)
//   operands   : [11:8] dst; [7:0] immediate, or [7:4] src A / [3:0] src B
//   alu_cmd    : alu::AluCmd operation select
//   ctrl_sig   : ctrl::CtrlSig {reg_wr_en, dst_in_sel}
//   alu_result : combinational ALU output for the current src A / src B
//   rd_a, rd_b : combinational reads of src A / src B (no write bypass)
//   flags      : {N,V,C,Z}, only when DATAPATH_FLAGS_EN is defined
// Build option: `define DATAPATH_FLAGS_EN to add the flags register and port.
// DATA_W must be 8 because the immediate field is fixed at 8 bits.
// ---------------------------------------------------------------------------
module data_path
   import data_path_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int NUM_REGS = NUM_REGS_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [OPND_W-1:0] operands,
   input  alu::AluCmd        alu_cmd,
   input  ctrl::CtrlSig      ctrl_sig,
   output logic [DATA_W-1:0] alu_result,
   output logic [DATA_W-1:0] rd_a,
   output logic [DATA_W-1:0] rd_b
`ifdef DATAPATH_FLAGS_EN
   ,
   output logic [3:0]        flags
`endif
);

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [3:0]        dst_addr;
   logic [3:0]        srca_addr;
   logic [3:0]        srcb_addr;
   logic [DATA_W-1:0] imm;
   logic              alu_carry;
   logic              alu_ovf;

   assign dst_addr  = operands[DST_MSB:DST_LSB];
   assign srca_addr = operands[SRCA_MSB:SRCA_LSB];
   assign srcb_addr = operands[SRCB_MSB:SRCB_LSB];
   assign imm       = operands[IMM_MSB:IMM_LSB];

   assign rd_a = regs[srca_addr];
   assign rd_b = regs[srcb_addr];

   alu_unit #(.DATA_W(DATA_W)) u_alu (
      .a        (rd_a),
      .b        (rd_b),
      .cmd      (alu_cmd),
      .result   (alu_result),
      .carry    (alu_carry),
      .overflow (alu_ovf)
   );

   // Reads see pre-edge contents, so r5 = r5 + r1 uses the old r5.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (ctrl_sig.reg_wr_en) begin
         regs[dst_addr] <= ctrl_sig.dst_in_sel ? imm : alu_result;
      end
   end

`ifdef DATAPATH_FLAGS_EN
   // Flags track ALU writes only; immediate loads leave them untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags <= 4'b0000;
      end else if (ctrl_sig.reg_wr_en && !ctrl_sig.dst_in_sel) begin
         flags <= {alu_result[DATA_W-1], alu_ovf, alu_carry, (alu_result == '0)};
      end
   end
`else
   logic unused_alu_status;
   assign unused_alu_status = alu_carry ^ alu_ovf;
`endif

endmodule

// File: tb/tb_data_path.sv
module tb_data_path;
   import data_path_pkg::*;

   logic         clk;
   logic         rst_n;
   logic [11:0]  operands;
   alu::AluCmd   alu_cmd;
   ctrl::CtrlSig ctrl_sig;
   logic [7:0]   alu_result;
   logic [7:0]   rd_a;
   logic [7:0]   rd_b;
`ifdef DATAPATH_FLAGS_EN
   logic [3:0]   flags;
`endif

   int checks = 0;
   int errors = 0;

   data_path dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .operands   (operands),
      .alu_cmd    (alu_cmd),
      .ctrl_sig   (ctrl_sig),
      .alu_result (alu_result),
      .rd_a       (rd_a),
      .rd_b       (rd_b)
`ifdef DATAPATH_FLAGS_EN
      ,
      .flags      (flags)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   // Advance past one rising edge, landing 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic wr, input logic sel, input logic [11:0] op,
                        input alu::AluCmd cmd);
      ctrl_sig.reg_wr_en  = wr;
      ctrl_sig.dst_in_sel = sel;
      operands            = op;
      alu_cmd             = cmd;
   endtask

   initial begin
      logic [3:0] idx;
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 12'h000, alu::ADD);
      #12;
      check("reset_rd_a", rd_a, 8'h00);
`ifdef DATAPATH_FLAGS_EN
      check("reset_flags", {4'h0, flags}, 8'h00);
`endif
      tick();
      rst_n = 1'b1;

      // Every register reads zero after reset
      for (int i = 0; i < 16; i++) begin
         idx = i[3:0];
         drive(1'b0, 1'b0, {4'h0, idx, idx}, alu::ADD);
         #1;
         check($sformatf("reset_r%0d_a", i), rd_a, 8'h00);
         check($sformatf("reset_r%0d_b", i), rd_b, 8'h00);
      end

      // Init r1 = 20, r3 = 10, then r5 = r1 + r3
      drive(1'b1, 1'b1, {4'd1, 8'd20}, alu::ADD);
      tick();
      drive(1'b1, 1'b1, {4'd3, 8'd10}, alu::ADD);
      tick();
      drive(1'b1, 1'b0, {4'd5, 4'd1, 4'd3}, alu::ADD);
      #1;
      check("init_rd_a", rd_a, 8'd20);
      check("init_rd_b", rd_b, 8'd10);
      check("add_30", alu_result, 8'd30);
      tick();
      drive(1'b0, 1'b0, {4'd0, 4'd5, 4'd0}, alu::ADD);
      #1;
      check("r5_30", rd_a, 8'h1E);
`ifdef DATAPATH_FLAGS_EN
      check("flags_add30", {4'h0, flags}, 8'h00);
`endif

      // Self-update r5 = r5 + r1 twice
      drive(1'b1, 1'b0, {4'd5, 4'd5, 4'd1}, alu::ADD);
      #1;
      check("self_pre", alu_result, 8'd50);
      tick();
      check("self_r5_50", rd_a, 8'd50);
      check("self_next", alu_result, 8'd70);
      tick();
      check("self_r5_70", rd_a, 8'd70);

      // Wrap: r1 = 200, r2 = 100, r4 = r1 + r2 = 44
      drive(1'b1, 1'b1, {4'd1, 8'd200}, alu::ADD);
      tick();
      drive(1'b1, 1'b1, {4'd2, 8'd100}, alu::ADD);
      tick();
      drive(1'b1, 1'b0, {4'd4, 4'd1, 4'd2}, alu::ADD);
      #1;
      check("wrap_add", alu_result, 8'd44);
      tick();
      drive(1'b0, 1'b0, {4'd0, 4'd4, 4'd2}, alu::ADD);
      #1;
      check("r4_44", rd_a, 8'd44);
`ifdef DATAPATH_FLAGS_EN
      check("flags_wrap_add", {4'h0, flags}, 8'h02);
`endif

      // SUB r7 = r2 - r1 = 0x9C with borrow and signed overflow
      drive(1'b1, 1'b0, {4'd7, 4'd2, 4'd1}, alu::SUB);
      #1;
      check("sub_9c", alu_result, 8'h9C);
      tick();
      drive(1'b0, 1'b0, {4'd0, 4'd7, 4'd0}, alu::PASSA);
      #1;
      check("r7_9c", rd_a, 8'h9C);
`ifdef DATAPATH_FLAGS_EN
      check("flags_sub", {4'h0, flags}, 8'h0E);
`endif

      // Remaining operations on A = r1 = 0xC8, B = r2 = 0x64, no writes
      drive(1'b0, 1'b0, {4'd0, 4'd1, 4'd2}, alu::AND);
      #1; check("op_and", alu_result, 8'h40);
      alu_cmd = alu::OR;    #1; check("op_or", alu_result, 8'hEC);
      alu_cmd = alu::XOR;   #1; check("op_xor", alu_result, 8'hAC);
      alu_cmd = alu::NOT;   #1; check("op_not", alu_result, 8'h37);
      alu_cmd = alu::SHL;   #1; check("op_shl", alu_result, 8'h90);
      alu_cmd = alu::SHR;   #1; check("op_shr", alu_result, 8'h64);
      alu_cmd = alu::PASSA; #1; check("op_passa", alu_result, 8'hC8);
      alu_cmd = alu::PASSB; #1; check("op_passb", alu_result, 8'h64);
      alu_cmd = alu::AluCmd'(4'hF); #1; check("op_undef", alu_result, 8'h00);
      tick();
`ifdef DATAPATH_FLAGS_EN
      check("flags_hold", {4'h0, flags}, 8'h0E);
`endif

      // Zero result: r8 = r1 - r1
      drive(1'b1, 1'b0, {4'd8, 4'd1, 4'd1}, alu::SUB);
      #1;
      check("sub_zero", alu_result, 8'h00);
      tick();
`ifdef DATAPATH_FLAGS_EN
      check("flags_zero", {4'h0, flags}, 8'h01);
`endif

      // Write disabled: r6 must stay zero
      drive(1'b0, 1'b1, {4'd6, 8'hAA}, alu::ADD);
      tick();
      drive(1'b0, 1'b0, {4'd0, 4'd6, 4'd0}, alu::ADD);
      #1;
      check("wr_disable_r6", rd_a, 8'h00);

      // Register 0 is writable
      drive(1'b1, 1'b1, {4'd0, 8'h5A}, alu::ADD);
      tick();
      drive(1'b0, 1'b0, {4'd0, 4'd0, 4'd0}, alu::ADD);
      #1;
      check("r0_write", rd_b, 8'h5A);

      // Asynchronous reset between edges with a write pending
      drive(1'b1, 1'b1, {4'd9, 8'h15}, alu::ADD);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_r1", rd_a, 8'h00);
      check("async_r5", rd_b, 8'h00);
`ifdef DATAPATH_FLAGS_EN
      check("async_flags", {4'h0, flags}, 8'h00);
`endif
      operands = {4'd9, 8'h99};
      tick();
      check("reset_blocks_write", rd_a, 8'h00);
      rst_n = 1'b1;
      ctrl_sig.reg_wr_en = 1'b0;
      tick();
      check("after_release_r9", rd_a, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
